// File: rtl/cdb_buffered.sv
// -----------------------------------------------------------------------------
// cdb_buffered
//   Buffered common data bus. Each functional unit writes completed results
//   into its own DEPTH-entry FIFO. Every cycle up to N candidates (FIFO head,
//   or the incoming packet when the FIFO is empty) are granted onto N
//   registered broadcast lanes. Arbitration is either fixed (lowest FU index
//   first) or round-robin. Buffered results follow branch resolution:
//   squashed entries lose their valid bit in place and are popped without a
//   lane, and cleared branch bits are removed from every stored entry.
//
// Ports
//   clock        sole clock, rising edge
//   reset        asynchronous, active-low
//   fu_done      [NUM_FU]          FU j presents a packet on wr_data[j]
//   wr_data      [NUM_FU*FU_W]     FU result packets
//   fu_ready     [NUM_FU]          FIFO j can accept (count_j < DEPTH)
//   rem_br_task  [2]               0 = none, 1 = SQUASH, 2 = CLEAR
//   rem_b_id     [BR_W]            one-hot branch being resolved
//   entries      [N*CDB_W]         registered broadcast lanes
//   occupancy    [NUM_FU*CNT_W]    per-FU FIFO count
//
// FU packet layout (LSB first):
//   result[XLEN] | dest_reg_idx[AREG_W] | preg_idx[PREG_W] | valid | b_mask[BR_W] | b_id[BR_W]
// CDB lane layout (MSB first):
//   {reg_idx[AREG_W], p_reg_idx[PREG_W], reg_val[XLEN], valid}
// -----------------------------------------------------------------------------
module cdb_buffered #(
    parameter int N      = 2,
    parameter int NUM_FU = 4,
    parameter int DEPTH  = 2,
    parameter int RR     = 1,
    parameter int XLEN   = 32,
    parameter int AREG_W = 5,
    parameter int PREG_W = 6,
    parameter int BR_W   = 4,
    localparam int FU_W  = XLEN + AREG_W + PREG_W + 1 + 2 * BR_W,
    localparam int CDB_W = AREG_W + PREG_W + XLEN + 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_FU-1:0]         fu_done,
    input  logic [NUM_FU*FU_W-1:0]    wr_data,
    output logic [NUM_FU-1:0]         fu_ready,
    input  logic [1:0]                rem_br_task,
    input  logic [BR_W-1:0]           rem_b_id,
    output logic [N*CDB_W-1:0]        entries,
    output logic [NUM_FU*CNT_W-1:0]   occupancy
);

    // Branch task encoding (0 means no resolution this cycle)
    localparam logic [1:0] BR_SQUASH = 2'd1;
    localparam logic [1:0] BR_CLEAR  = 2'd2;

    localparam int RES_LSB  = 0;
    localparam int DEST_LSB = XLEN;
    localparam int PREG_LSB = DEST_LSB + AREG_W;
    localparam int VAL_BIT  = PREG_LSB + PREG_W;
    localparam int MASK_LSB = VAL_BIT + 1;
    localparam int BID_LSB  = MASK_LSB + BR_W;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    // Apply the current branch resolution to one packet. The resolving
    // branch itself (b_id == rem_b_id) is never squashed.
    function automatic logic [FU_W-1:0] br_filter(input logic [FU_W-1:0] pkt,
                                                  input logic [1:0]      br_task,
                                                  input logic [BR_W-1:0] bid);
        logic [FU_W-1:0] res;
        logic [BR_W-1:0] mask;
        logic [BR_W-1:0] own;
        res  = pkt;
        mask = pkt[MASK_LSB +: BR_W];
        own  = pkt[BID_LSB +: BR_W];
        if (br_task == BR_SQUASH && (mask & bid) != '0 && own != bid)
            res[VAL_BIT] = 1'b0;
        if (br_task == BR_CLEAR)
            res[MASK_LSB +: BR_W] = mask & ~bid;
        return res;
    endfunction

    function automatic logic [CDB_W-1:0] to_cdb(input logic [FU_W-1:0] pkt);
        return {pkt[DEST_LSB +: AREG_W], pkt[PREG_LSB +: PREG_W],
                pkt[RES_LSB +: XLEN], pkt[VAL_BIT]};
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic [FU_W-1:0]   cand_pkt [NUM_FU];
    logic [NUM_FU-1:0] cand_req;
    logic [NUM_FU-1:0] grant;
    logic [CDB_W-1:0]  lane_next [N];
    logic [CDB_W-1:0]  lane_reg  [N];
    logic [RR_W-1:0]   rr_ptr_reg;
    logic [RR_W-1:0]   rr_ptr_next;

    genvar gi;

    // ---------------------------------------------------------------- FIFOs
    for (gi = 0; gi < NUM_FU; gi++) begin : g_fu
        logic [FU_W-1:0]  mem_reg [DEPTH];
        logic [PTR_W-1:0] head_reg;
        logic [PTR_W-1:0] tail_reg;
        logic [CNT_W-1:0] count_reg;
        logic [FU_W-1:0]  in_pkt;
        logic [FU_W-1:0]  head_pkt;
        logic             accept;
        logic             present;
        logic             leave;
        logic             pop;
        logic             push;

        assign fu_ready[gi] = (count_reg < CNT_W'(DEPTH));
        assign accept       = fu_done[gi] && fu_ready[gi];
        assign in_pkt       = br_filter(wr_data[gi*FU_W +: FU_W], rem_br_task, rem_b_id);
        assign head_pkt     = br_filter(mem_reg[head_reg], rem_br_task, rem_b_id);

        // An empty FIFO lets the incoming packet bypass straight to arbitration.
        assign cand_pkt[gi] = (count_reg != '0) ? head_pkt : in_pkt;
        assign present      = (count_reg != '0) || accept;
        assign cand_req[gi] = present && cand_pkt[gi][VAL_BIT];

        // The candidate leaves when it is granted, or when it is invalid
        // (squashed) and simply dropped without occupying a lane.
        assign leave = present && (grant[gi] || !cand_pkt[gi][VAL_BIT]);
        assign pop   = leave && (count_reg != '0);
        assign push  = accept && !((count_reg == '0) && leave);

        assign occupancy[gi*CNT_W +: CNT_W] = count_reg;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                head_reg  <= '0;
                tail_reg  <= '0;
                count_reg <= '0;
                for (int k = 0; k < DEPTH; k++)
                    mem_reg[k] <= '0;
            end else begin
                // Stored entries track branch resolution in place.
                for (int k = 0; k < DEPTH; k++)
                    mem_reg[k] <= br_filter(mem_reg[k], rem_br_task, rem_b_id);
                if (push) begin
                    mem_reg[tail_reg] <= in_pkt;
                    tail_reg          <= ptr_inc(tail_reg);
                end
                if (pop)
                    head_reg <= ptr_inc(head_reg);
                if (push && !pop)
                    count_reg <= count_reg + CNT_W'(1);
                else if (pop && !push)
                    count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

    // ---------------------------------------------------------- arbitration
    // Scan position k maps to FU (start + k) mod NUM_FU; granted candidates
    // fill lanes in scan order. Loops use constant indices only so the
    // selection stays a plain mux tree.
    always_comb begin : arb
        int start;
        int pos;
        int n_granted;
        grant       = '0;
        rr_ptr_next = rr_ptr_reg;
        for (int l = 0; l < N; l++)
            lane_next[l] = '0;
        start     = (RR != 0) ? int'(rr_ptr_reg) : 0;
        n_granted = 0;
        for (int k = 0; k < NUM_FU; k++) begin
            pos = start + k;
            if (pos >= NUM_FU)
                pos = pos - NUM_FU;
            for (int j = 0; j < NUM_FU; j++) begin
                if (pos == j && cand_req[j] && n_granted < N) begin
                    grant[j] = 1'b1;
                    for (int l = 0; l < N; l++)
                        if (n_granted == l)
                            lane_next[l] = to_cdb(cand_pkt[j]);
                    n_granted = n_granted + 1;
                    if (RR != 0)
                        rr_ptr_next = RR_W'((j + 1) % NUM_FU);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_reg <= '0;
            for (int l = 0; l < N; l++)
                lane_reg[l] <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            for (int l = 0; l < N; l++)
                lane_reg[l] <= lane_next[l];
        end
    end

    for (gi = 0; gi < N; gi++) begin : g_lane
        assign entries[gi*CDB_W +: CDB_W] = lane_reg[gi];
    end

endmodule
